// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, CALC} state_t;
  state_t             state_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d, p_q;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, last;
  always_comb begin
    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_d = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
    last     = (cnt_q == CW'(WIDTH - 1)) || (mplier_d == '0);
`else
    last     = cnt_q == CW'(WIDTH - 1);
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
`ifdef MULT_EARLY_TERM_EN
          if (A == '0 || B == '0) begin
            p_q    <= '0;
            done_q <= 1'b1;
          end else
`endif
          begin
            mcand_q  <= {{WIDTH{1'b0}}, A};
            mplier_q <= B;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= CALC;
            busy_q   <= 1'b1;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            p_q     <= acc_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of the shift-add multiplier for WIDTH=4.
module tb_shift_add_multiplier;
  localparam int W = 4;
  logic           clk = 1'b0;
  logic           rst_n, start;
  logic [W-1:0]   A, B;
  logic           busy, done;
  logic [2*W-1:0] P;
  int checks = 0, errors = 0, pulses = 0;
  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .P(P)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) pulses++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int exp_lat(input int a, input int b);
`ifdef MULT_EARLY_TERM_EN
    if (a == 0 || b == 0) return 0;
    for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
`endif
    return W;
  endfunction
  task automatic start_op(input int a, input int b);
    A = W'(a);
    B = W'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      chk("busy_during_op", 32'(busy), 1);
      tick();
      n++;
    end
  endtask
  task automatic run_op(input int a, input int b);
    int n;
    start_op(a, b);
    wait_done(n);
    chk("latency", n, exp_lat(a, b));
    chk("product", 32'(P), a * b);
    chk("busy_at_done", 32'(busy), 0);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("product_hold", 32'(P), a * b);
  endtask
  initial begin
    int n, p0;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_P", 32'(P), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_done", 32'(done), 0);
    run_op(5, 2);
    repeat (3) tick();
    chk("P_holds_10", 32'(P), 10);
    // back-to-back: second start lands in the first done cycle
    p0 = pulses;
    start_op(15, 15);
    wait_done(n);
    chk("b2b_lat1", n, exp_lat(15, 15));
    chk("b2b_P1", 32'(P), 225);
    start_op(7, 3);
    wait_done(n);
    chk("b2b_lat2", n, exp_lat(7, 3));
    chk("b2b_P2", 32'(P), 21);
    tick();
    chk("b2b_pulses", pulses - p0, 2);
    // start during busy must be ignored
    start_op(9, 5);
    A = 4'd1;
    B = 4'd1;
    start = 1'b1;
    chk("ign_busy1", 32'(busy), 1);
    tick();
    chk("ign_busy2", 32'(busy), 1);
    tick();
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 40) begin
      chk("ign_busy_rest", 32'(busy), 1);
      tick();
      n++;
    end
    chk("ign_lat", n, exp_lat(9, 5));
    chk("ign_P", 32'(P), 45);
    tick();
    chk("ign_no_restart", 32'(busy), 0);
    run_op(0, 9);
    run_op(9, 0);
    run_op(15, 1);
    // reset aborts an operation in flight
    run_op(9, 5);
    p0 = pulses;
    start_op(10, 4);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_P", 32'(P), 0);
    repeat (6) tick();
    chk("abort_no_pulse", pulses - p0, 0);
    run_op(10, 4);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) run_op(a, b);
    // divider cross-check: Q*B + R == A
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++) begin
        start_op(a / b, b);
        wait_done(n);
        chk("div_check", 32'(P) + 32'(a % b), a);
        tick();
      end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential unsigned shift-and-add multiplier, the inverse operation of the team's combinational array divider. It computes P = A * B one multiplier bit per clock, under a start/done handshake. It also serves as the check path for divider results: Q*B + R must equal A. Its area is a fraction of an array multiplier, so it is used wherever several cycles of latency are acceptable.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal range 2..16.

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request; sampled only while idle (busy=0)
A  input  WIDTH  multiplicand, unsigned; captured on accepted start
B  input  WIDTH  multiplier, unsigned; captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; P valid from this cycle onward
P  output  2*WIDTH  product; holds last result until the next result is written

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, P=0, all internal registers cleared. Reset mid-operation aborts the operation; no done pulse is produced for it.
- States: IDLE, CALC.
- IDLE, start=1 at edge k (accept):
  - mcand <= zero-extended A (2*WIDTH bits); mplier <= B; acc <= 0; cnt <= 0.
  - state <= CALC; busy <= 1.
- IDLE, start=0: state stays IDLE.
- CALC, each edge:
  - acc_next = acc + (mplier[0] ? mcand : 0), computed in 2*WIDTH bits; cannot overflow.
  - mcand <<= 1; mplier >>= 1; cnt++.
- Completion: at the edge where cnt reaches WIDTH (edge k+WIDTH), that edge's iteration still executes, then:
  - P <= acc_next; done <= 1; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 edges after the edge that accepted start.
- done is high for exactly one cycle and is cleared at the next edge unless a new completion occurs at that edge.
- start while busy=1 is ignored. It is neither queued nor allowed to disturb the operands.
- start=1 during the done cycle (state IDLE) is accepted. Back-to-back throughput is therefore one result per WIDTH+1 cycles.
- A and B may change freely after the accepting edge.
- P is updated only at completion; it is never partially updated.
- Boundaries:
  - A=0 or B=0 completes with P=0 at full latency (macro off).
  - Max operands: (2^WIDTH-1)^2 fits exactly in P; for WIDTH=4, 15*15=225.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - At accept, if A==0 or B==0: P <= 0 and done <= 1 at the same edge k; busy stays 0; no CALC cycles.
  - In CALC, if the shifted mplier becomes 0: completion occurs at that edge with P <= acc_next, regardless of cnt. Example: 15*1 gives done after edge k+1.
- Undefined: fixed WIDTH-iteration latency for all operands, as described above.
- Results are identical either way; only latency differs.

Test Plan:
- WIDTH=4, A=5, B=2, start pulsed one cycle -> busy=1 for 4 cycles; done pulses in cycle k+5 with P=10; P holds 10 afterwards.
- A=15, B=15, then A=7, B=3 with start asserted during the first done cycle -> P=225, then P=21 exactly 5 cycles later; two done pulses total.
- A=9, B=5 accepted; start re-asserted with A=1, B=1 during busy -> ignored; P=45 at normal latency; busy waveform unchanged.
- A=0, B=9 -> P=0. Macro off: done at k+5. Macro on: done at k+1, busy never high.
- rst_n driven low 2 cycles into A=10, B=4 -> next edge busy=0, done=0, P=0. A new start afterwards yields P=40 with no spurious done.
- Exhaustive 16x16 operand sweep, each checked as P==A*B, plus the divider cross-check Q*B+R==A for all B!=0.
